// File: rtl/passcode_lock_ctrl_pkg.sv
// Shared definitions for the passcode lock controller: FSM state encoding,
// BCD digit constants and a counter-width helper.
package lock_pkg;

   localparam int             BCD_W   = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   localparam logic [2:0] ENTRY    = 3'd0;
   localparam logic [2:0] CHECK    = 3'd1;
   localparam logic [2:0] UNLOCKED = 3'd2;
   localparam logic [2:0] ALARM    = 3'd3;
   localparam logic [2:0] LOCKOUT  = 3'd4;

   // Number of bits needed to hold max_val (at least 1).
   function automatic int cnt_width(input int unsigned max_val);
      int w;
      w = 1;
      while ((max_val >> w) != 0) w++;
      return w;
   endfunction

endpackage

// File: rtl/passcode_lock_ctrl_if.sv
// Key-event and status bundle between the keypad encoder side and the lock
// controller. master drives key events, slave is the controller.
interface passcode_lock_if;
   import lock_pkg::*;

   logic             key_valid;
   logic [BCD_W-1:0] key_digit;
   logic             key_enter;
   logic             key_clear;
   logic             lock_req;
   logic             alarm_clr;
   logic             unlocked;
   logic             alarm;
   logic             lockout;
   logic             code_updated;
   logic [3:0]       attempts;
   logic [3:0]       digit_cnt;

   modport master (
      output key_valid, key_digit, key_enter, key_clear, lock_req, alarm_clr,
      input  unlocked, alarm, lockout, code_updated, attempts, digit_cnt
   );

   modport slave (
      input  key_valid, key_digit, key_enter, key_clear, lock_req, alarm_clr,
      output unlocked, alarm, lockout, code_updated, attempts, digit_cnt
   );

endinterface

// File: rtl/passcode_lock_ctrl_bcd_entry_buffer.sv
// Entry buffer: shift register of BCD digits plus a saturating digit count.
// New digits enter the low nibble; once DIGITS are held further digits are
// dropped rather than wrapping.
module bcd_entry_buffer
   import lock_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    shift,
   input  logic [BCD_W-1:0]        digit,
   output logic [DIGITS*BCD_W-1:0] entry_buf,
   output logic [3:0]              digit_cnt
);

   localparam int         W        = DIGITS * BCD_W;
   localparam logic [3:0] FULL_CNT = 4'(DIGITS);

   logic full;
   assign full = (digit_cnt == FULL_CNT);

   // Clear wins over shift; shifting stops once the buffer is full.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entry_buf <= '0;
         digit_cnt <= '0;
      end else if (clr) begin
         entry_buf <= '0;
         digit_cnt <= '0;
      end else if (shift && !full) begin
         entry_buf <= (entry_buf << BCD_W) | W'(digit);
         digit_cnt <= digit_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/passcode_lock_ctrl.sv
// Passcode lock controller: accumulates BCD key entries, checks them against
// a programmable code, counts consecutive failures, raises a latched alarm
// and enforces a timed lockout after the alarm is acknowledged.
// Optional build macro PASSCODE_ENTRY_TIMEOUT_EN adds an inter-key idle
// timeout that discards a stale partial entry.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ENTRY    | locked, collecting digits
// CHECK    | one cycle compare of entry against stored code
// UNLOCKED | open; digits may be entered to re-program the code
// ALARM    | failure limit reached, waiting for alarm_clr
// LOCKOUT  | timed penalty, all keys ignored
module passcode_lock_ctrl
   import lock_pkg::*;
#(
   parameter int                       DIGITS         = 4,
   parameter int                       MAX_ATTEMPTS   = 3,
   parameter int                       LOCKOUT_CYCLES = 1024,
   parameter logic [DIGITS*BCD_W-1:0]  DEFAULT_CODE   = '0,
   parameter int                       TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst,
   passcode_lock_if.slave   bus
);

   localparam int                CODE_W   = DIGITS * BCD_W;
   localparam int                TMR_W    = cnt_width(LOCKOUT_CYCLES - 1);
   localparam logic [3:0]        FULL_CNT = 4'(DIGITS);
   localparam logic [3:0]        MAX_ATT  = 4'(MAX_ATTEMPTS);
   localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("DIGITS must be 1..8");
   end
   if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15) begin : g_bad_attempts
      $error("MAX_ATTEMPTS must be 1..15");
   end
   if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
      $error("LOCKOUT_CYCLES must be >= 1");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 1");
   end

   logic [2:0]        state;
   logic [CODE_W-1:0] stored_code;
   logic [CODE_W-1:0] entry_buf;
   logic [3:0]        digit_cnt;
   logic [3:0]        attempts;
   logic [3:0]        attempts_next;
   logic [TMR_W-1:0]  timer;
   logic              force_fail;
   logic              code_updated;
   logic              buf_clr;
   logic              buf_shift;
   logic              digit_ok;
   logic              entry_full;
   logic              code_match;
   logic              timeout;

   assign digit_ok      = bus.key_valid && (bus.key_digit <= BCD_MAX);
   assign entry_full    = (digit_cnt == FULL_CNT);
   assign code_match    = !force_fail && (entry_buf == stored_code);
   assign attempts_next = (attempts >= MAX_ATT) ? MAX_ATT : attempts + 4'd1;

   bcd_entry_buffer #(.DIGITS(DIGITS)) u_entry_buf (
      .clk       (clk),
      .rst       (rst),
      .clr       (buf_clr),
      .shift     (buf_shift),
      .digit     (bus.key_digit),
      .entry_buf (entry_buf),
      .digit_cnt (digit_cnt)
   );

`ifdef PASSCODE_ENTRY_TIMEOUT_EN
   localparam int                IDLE_W    = cnt_width(TIMEOUT_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT_CYCLES - 1);

   logic [IDLE_W-1:0] idle_tmr;
   logic              idle_armed;
   logic              key_evt;

   assign key_evt    = bus.key_valid | bus.key_enter | bus.key_clear;
   assign idle_armed = (state == ENTRY) && (digit_cnt != 4'd0);
   assign timeout    = idle_armed && !key_evt && (idle_tmr == '0);

   // Idle down-counter; reloads on any key event or when nothing is pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              idle_tmr <= IDLE_LOAD;
      else if (!idle_armed || key_evt || timeout) idle_tmr <= IDLE_LOAD;
      else                                   idle_tmr <= idle_tmr - IDLE_W'(1);
   end
`else
   assign timeout = 1'b0;
`endif

   // Buffer controls; key_clear beats key_enter beats key_valid, and lock_req
   // beats everything while unlocked.
   always_comb begin
      buf_clr   = 1'b0;
      buf_shift = 1'b0;
      case (state)
         ENTRY: begin
            buf_clr   = bus.key_clear | timeout;
            buf_shift = digit_ok & ~bus.key_clear & ~bus.key_enter;
         end
         CHECK: buf_clr = 1'b1;
         UNLOCKED: begin
            buf_clr   = bus.lock_req | bus.key_clear | bus.key_enter;
            buf_shift = digit_ok & ~bus.lock_req & ~bus.key_clear & ~bus.key_enter;
         end
         default: ;
      endcase
   end

   // Main sequencing: check, failure counting, code programming, lockout timer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ENTRY;
         attempts     <= '0;
         timer        <= '0;
         force_fail   <= 1'b0;
         stored_code  <= DEFAULT_CODE;
         code_updated <= 1'b0;
      end else begin
         code_updated <= 1'b0;
         case (state)
            ENTRY: begin
               if (bus.key_enter && !bus.key_clear) begin
                  state      <= CHECK;
                  force_fail <= !entry_full;
               end
            end
            CHECK: begin
               force_fail <= 1'b0;
               if (code_match) begin
                  state    <= UNLOCKED;
                  attempts <= '0;
               end else begin
                  attempts <= attempts_next;
                  state    <= (attempts_next == MAX_ATT) ? ALARM : ENTRY;
               end
            end
            UNLOCKED: begin
               if (bus.lock_req) begin
                  state <= ENTRY;
               end else if (bus.key_enter && !bus.key_clear && entry_full) begin
                  stored_code  <= entry_buf;
                  code_updated <= 1'b1;
               end
            end
            ALARM: begin
               if (bus.alarm_clr) begin
                  state <= LOCKOUT;
                  timer <= TMR_LOAD;
               end
            end
            LOCKOUT: begin
               if (timer == '0) begin
                  state    <= ENTRY;
                  attempts <= '0;
               end else begin
                  timer <= timer - TMR_W'(1);
               end
            end
            default: state <= ENTRY;
         endcase
      end
   end

   assign bus.unlocked     = (state == UNLOCKED);
   assign bus.alarm        = (state == ALARM);
   assign bus.lockout      = (state == LOCKOUT);
   assign bus.code_updated = code_updated;
   assign bus.attempts     = attempts;
   assign bus.digit_cnt    = digit_cnt;

endmodule

// File: tb/tb_passcode_lock_ctrl.sv
// Directed bench for passcode_lock_ctrl (default 4-digit, 3-attempt,
// 1024-cycle lockout configuration). Expected status words are queued as
// each step is driven and compared once the clock edge has taken effect.
module tb_passcode_lock_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   passcode_lock_if bus ();

   passcode_lock_ctrl #(
      .DIGITS         (4),
      .MAX_ATTEMPTS   (3),
      .LOCKOUT_CYCLES (1024),
      .DEFAULT_CODE   (16'h0000),
      .TIMEOUT_CYCLES (4096)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [11:0] v;
   } exp_t;

   exp_t sb[$];
   int   tests  = 0;
   int   failed = 0;

   // {unlocked, alarm, lockout, code_updated, attempts, digit_cnt}
   function automatic logic [11:0] ex(input logic u, input logic a, input logic l,
                                      input logic cu, input logic [3:0] att,
                                      input logic [3:0] dc);
      return {u, a, l, cu, att, dc};
   endfunction

   function automatic logic [11:0] obs();
      return {bus.unlocked, bus.alarm, bus.lockout, bus.code_updated,
              bus.attempts, bus.digit_cnt};
   endfunction

   task automatic clear_in();
      bus.key_valid = 1'b0;
      bus.key_digit = 4'd0;
      bus.key_enter = 1'b0;
      bus.key_clear = 1'b0;
      bus.lock_req  = 1'b0;
      bus.alarm_clr = 1'b0;
   endtask

   task automatic sb_check();
      exp_t e;
      e = sb.pop_front();
      tests++;
      assert (obs() === e.v) else begin
         failed++;
         $error("FAIL %s observed=%03h expected=%03h", e.tag, obs(), e.v);
      end
   endtask

   task automatic check_now(input string tag, input logic [11:0] e);
      sb.push_back('{tag, e});
      sb_check();
   endtask

   task automatic step_exp(input string tag, input logic [11:0] e);
      sb.push_back('{tag, e});
      @(posedge clk);
      #1;
      clear_in();
      sb_check();
   endtask

   task automatic press(input logic [3:0] d, input string tag, input logic [11:0] e);
      bus.key_valid = 1'b1;
      bus.key_digit = d;
      step_exp(tag, e);
   endtask

   task automatic code4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic u, input logic [3:0] att);
      press(a, "digit_1", ex(u, 0, 0, 0, att, 4'd1));
      press(b, "digit_2", ex(u, 0, 0, 0, att, 4'd2));
      press(c, "digit_3", ex(u, 0, 0, 0, att, 4'd3));
      press(d, "digit_4", ex(u, 0, 0, 0, att, 4'd4));
   endtask

   task automatic submit(input string tag, input logic [11:0] e_chk, input logic [11:0] e_done);
      bus.key_enter = 1'b1;
      step_exp({tag, "_check"}, e_chk);
      step_exp(tag, e_done);
   endtask

   task automatic lock();
      bus.lock_req = 1'b1;
      step_exp("relock", ex(0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      clear_in();
      #2 rst = 1'b0;
      #2 check_now("reset_state", ex(0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Default code unlocks, two cycles after enter
      code4(0, 0, 0, 0, 0, 4'd0);
      submit("t1_default_unlock", ex(0, 0, 0, 0, 0, 4), ex(1, 0, 0, 0, 0, 0));

      // Program 1234, relock, new code opens, old code fails
      code4(1, 2, 3, 4, 1, 4'd0);
      bus.key_enter = 1'b1;
      step_exp("t2_program", ex(1, 0, 0, 1, 0, 0));
      step_exp("t2_pulse_end", ex(1, 0, 0, 0, 0, 0));
      lock();
      code4(1, 2, 3, 4, 0, 4'd0);
      submit("t2_new_code", ex(0, 0, 0, 0, 0, 4), ex(1, 0, 0, 0, 0, 0));
      lock();
      code4(0, 0, 0, 0, 0, 4'd0);
      submit("t2_old_code", ex(0, 0, 0, 0, 0, 4), ex(0, 0, 0, 0, 1, 0));

      // Clear attempts with a good entry, then three failures to alarm
      code4(1, 2, 3, 4, 0, 4'd1);
      submit("t3_reset_att", ex(0, 0, 0, 0, 1, 4), ex(1, 0, 0, 0, 0, 0));
      lock();
      for (int k = 0; k < 3; k++) begin
         code4(5, 5, 5, 5, 0, 4'(k));
         submit("t3_fail", ex(0, 0, 0, 0, 4'(k), 4),
                (k == 2) ? ex(0, 1, 0, 0, 3, 0) : ex(0, 0, 0, 0, 4'(k + 1), 0));
      end
      press(1, "t3_alarm_digit", ex(0, 1, 0, 0, 3, 0));
      bus.key_enter = 1'b1;
      step_exp("t3_alarm_enter", ex(0, 1, 0, 0, 3, 0));
      bus.lock_req = 1'b1;
      step_exp("t3_alarm_lockreq", ex(0, 1, 0, 0, 3, 0));
      bus.alarm_clr = 1'b1;
      step_exp("t3_lockout_start", ex(0, 0, 1, 0, 3, 0));
      n = 1;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         if (bus.lockout) n++;
         else break;
      end
      tests++;
      assert (n === 1024) else begin
         failed++;
         $error("FAIL t3_lockout_len observed=%0d expected=%0d", n, 1024);
      end
      check_now("t3_after_lockout", ex(0, 0, 0, 0, 0, 0));

      // Fifth digit dropped (1234 still opens), invalid digits, short entry
      code4(1, 2, 3, 4, 0, 4'd0);
      press(5, "t4_fifth_digit", ex(0, 0, 0, 0, 0, 4));
      submit("t4_saturated", ex(0, 0, 0, 0, 0, 4), ex(1, 0, 0, 0, 0, 0));
      lock();
      press(12, "t4_digit_12", ex(0, 0, 0, 0, 0, 0));
      press(7, "t4_digit_7", ex(0, 0, 0, 0, 0, 1));
      press(8, "t4_digit_8", ex(0, 0, 0, 0, 0, 2));
      press(15, "t4_digit_15", ex(0, 0, 0, 0, 0, 2));
      submit("t4_short_entry", ex(0, 0, 0, 0, 0, 2), ex(0, 0, 0, 0, 1, 0));

      // key_clear beats key_enter; lock_req beats key_enter
      code4(1, 2, 3, 4, 0, 4'd1);
      bus.key_clear = 1'b1;
      bus.key_enter = 1'b1;
      step_exp("t5_clear_enter", ex(0, 0, 0, 0, 1, 0));
      step_exp("t5_no_check", ex(0, 0, 0, 0, 1, 0));
      code4(1, 2, 3, 4, 0, 4'd1);
      submit("t5_unlock", ex(0, 0, 0, 0, 1, 4), ex(1, 0, 0, 0, 0, 0));
      code4(9, 9, 9, 9, 1, 4'd0);
      bus.lock_req  = 1'b1;
      bus.key_enter = 1'b1;
      step_exp("t5_lock_wins", ex(0, 0, 0, 0, 0, 0));
      step_exp("t5_no_update", ex(0, 0, 0, 0, 0, 0));
      code4(1, 2, 3, 4, 0, 4'd0);
      submit("t5_code_kept", ex(0, 0, 0, 0, 0, 4), ex(1, 0, 0, 0, 0, 0));

      // Async reset in LOCKOUT after programming restores default code
      lock();
      for (int k = 0; k < 3; k++) begin
         code4(5, 5, 5, 5, 0, 4'(k));
         submit("t6_fail", ex(0, 0, 0, 0, 4'(k), 4),
                (k == 2) ? ex(0, 1, 0, 0, 3, 0) : ex(0, 0, 0, 0, 4'(k + 1), 0));
      end
      bus.alarm_clr = 1'b1;
      step_exp("t6_lockout", ex(0, 0, 1, 0, 3, 0));
      repeat (10) @(posedge clk);
      #3 check_now("t6_mid_lockout", ex(0, 0, 1, 0, 3, 0));
      rst = 1'b0;
      #1 check_now("t6_async_reset", ex(0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1 rst = 1'b1;
      code4(0, 0, 0, 0, 0, 4'd0);
      submit("t6_default_code", ex(0, 0, 0, 0, 0, 4), ex(1, 0, 0, 0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/passcode_lock_ctrl.md
Name: passcode_lock_ctrl

Overview:
- Parametrised successor to the single-code keypad lock datapath.
- Takes pre-encoded BCD key events and accumulates a DIGITS-long entry.
- Compares the entry against a programmable stored code and counts failed attempts up to MAX_ATTEMPTS.
- Raises a latched alarm, then enforces a timed lockout; allows re-programming of the code while unlocked.
- Sits between the keypad encoder and the actuator/alarm drivers.

Parameters:
- DIGITS, 4: code length in BCD digits (1..8).
- MAX_ATTEMPTS, 3: consecutive failures that trigger the alarm (1..15).
- LOCKOUT_CYCLES, 1024: clk cycles spent in LOCKOUT after alarm clear (>=1).
- DEFAULT_CODE, all-zero DIGITS*4 bits: code loaded on reset.
- TIMEOUT_CYCLES, 4096: inter-key idle limit (used only with the optional feature).

Ports:
- clk  in  1  system clock; all flops rising-edge.
- rst  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe; key_digit is valid.
- key_digit  in  4  BCD digit 0..9; values 10..15 are ignored.
- key_enter  in  1  one-cycle submit strobe.
- key_clear  in  1  one-cycle strobe; clears the entry buffer.
- lock_req  in  1  relock request, honoured in UNLOCKED only.
- alarm_clr  in  1  acknowledge alarm, honoured in ALARM only.
- unlocked  out  1  high in UNLOCKED.
- alarm  out  1  high in ALARM.
- lockout  out  1  high in LOCKOUT.
- code_updated  out  1  one-cycle pulse when a new code is stored.
- attempts  out  4  consecutive failure count.
- digit_cnt  out  4  digits currently buffered (0..DIGITS).

Behaviour:
- Reset (rst low, asynchronous):
  - state=ENTRY; entry buffer=0; digit_cnt=0; attempts=0; timer=0.
  - stored code=DEFAULT_CODE; all outputs 0.
  - Reset mid-operation aborts everything, including any programmed code.
- Key priority within one cycle: key_clear > key_enter > key_valid.
- Entry buffer rules (ENTRY and UNLOCKED states):
  - Valid digit with digit_cnt<DIGITS: buffer shifts left 4 bits, new digit enters the low nibble, digit_cnt+1.
  - Digit arriving when digit_cnt==DIGITS: ignored (no wrap).
  - key_clear: buffer and digit_cnt return to 0.
- State machine, ENTRY:
  - key_enter with digit_cnt==DIGITS -> CHECK.
  - key_enter with digit_cnt<DIGITS counts as a failure -> CHECK with forced mismatch.
- State machine, CHECK (exactly one cycle):
  - Buffer is cleared on exit.
  - Match -> UNLOCKED; attempts=0.
  - Mismatch -> attempts+1; if the new value equals MAX_ATTEMPTS -> ALARM, else -> ENTRY.
- State machine, UNLOCKED:
  - unlocked=1 from the cycle after CHECK.
  - key_enter with digit_cnt==DIGITS: stored code<=buffer; code_updated pulses next cycle; buffer cleared; stays UNLOCKED.
  - key_enter with a short entry: buffer cleared only.
  - lock_req -> ENTRY, buffer cleared. lock_req wins over key_enter in the same cycle.
- State machine, ALARM:
  - alarm=1; all key inputs ignored.
  - alarm_clr -> LOCKOUT; timer loaded with LOCKOUT_CYCLES-1.
- State machine, LOCKOUT:
  - lockout=1; keys ignored; timer decrements each cycle.
  - At timer==0 -> ENTRY; attempts=0.
  - Total residency is exactly LOCKOUT_CYCLES cycles.
- Latency: key_enter to unlocked/alarm is 2 cycles (enter registered, then CHECK).
- attempts saturates at MAX_ATTEMPTS and never wraps.

Optional Feature:
- Macro: PASSCODE_ENTRY_TIMEOUT_EN.
- Defined:
  - In ENTRY with digit_cnt>0, an idle counter counts cycles with no key_valid/key_enter/key_clear.
  - Reaching TIMEOUT_CYCLES clears the buffer and digit_cnt; attempts is unchanged.
  - Any key event restarts the counter.
- Undefined: no idle counter; a partial entry is held indefinitely.

Decomposition:
- Package lock_pkg holds:
  - State encoding constants ENTRY, CHECK, UNLOCKED, ALARM, LOCKOUT.
  - BCD_W=4 and BCD_MAX=9.
  - Count-width helper function (clog2).
- Natural sub-module: bcd_entry_buffer.
  - Contents: shift register plus digit counter with shift/clear controls.
  - Outputs: buffer and digit_cnt.
  - Instantiated once.

Test Plan:
1. Correct code: after reset, enter 0,0,0,0 then key_enter -> unlocked=1 two cycles after enter; attempts=0.
2. Program then relock: in UNLOCKED, keys 1,2,3,4 + key_enter -> code_updated pulse; lock_req; enter 1,2,3,4 -> unlocked=1; 0,0,0,0 -> attempts=1.
3. Failures to alarm: three wrong codes (5,5,5,5) -> attempts 1,2,3; alarm=1 after the third; keys ignored; alarm_clr -> lockout=1 for exactly 1024 cycles, then ENTRY with attempts=0.
4. Boundary keys: 5 digits entered -> digit_cnt saturates at 4, fifth ignored; digit 12 ignored; short entry (2 digits + enter) -> attempts+1.
5. Simultaneous events: key_clear+key_enter same cycle -> buffer cleared, no CHECK; lock_req+key_enter in UNLOCKED -> ENTRY, no code update.
6. Async reset mid-LOCKOUT and after programming: rst low -> all outputs 0 immediately; code reverts to DEFAULT_CODE (0,0,0,0 unlocks).
